// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B4 classic-cycle responder over a byte-writable word RAM.
// Programmable wait states, registered ack/err/data, out-of-range requests terminate with err.
module wb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int IW = $clog2(DEPTH);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("wb_sram_slave: WAIT_STATES must be 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [3:0]    cnt;
    logic [3:0]    cnt_d;

    logic [IW-1:0] req_idx;
    logic [31:0]   req_dat;
    logic [3:0]    req_sel;
    logic          req_we;
    logic          req_err;

    logic          cap;
    logic          ack_d;
    logic          err_d;
    logic          mem_we;

    logic          ack_q;
    logic          err_q;
    logic [31:0]   dat_q;

    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] in_idx;
    logic [31:0]   adr_hi;
    logic          in_oor;
    logic [IW-1:0] rd_idx;
    logic          rd_we;
    logic          resp_rd;

    logic          unused_ok;

    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign in_idx = wb_adr_i[IW+1:2];
    assign adr_hi = wb_adr_i >> (IW + 2);
    assign in_oor = (adr_hi != 32'd0) || (32'(in_idx) >= 32'(DEPTH));

    // With zero wait states the RAM is read on the capture edge itself,
    // so the read port must look at the live bus, not the request regs.
    assign rd_idx  = (state == ST_IDLE) ? in_idx  : req_idx;
    assign rd_we   = (state == ST_IDLE) ? wb_we_i : req_we;
    assign resp_rd = ack_d && !rd_we;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap     = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    cap = 1'b1;
                    if (in_oor) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                mem_we  = wb_cyc_i && req_we && !req_err && !wb_rst_i;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= resp_rd ? mem[rd_idx] : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_idx <= '0;
            req_dat <= 32'd0;
            req_sel <= 4'd0;
            req_we  <= 1'b0;
            req_err <= 1'b0;
        end else if (cap) begin
            req_idx <= in_idx;
            req_dat <= wb_dat_i;
            req_sel <= wb_sel_i;
            req_we  <= wb_we_i;
            req_err <= in_oor;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed vectors and multi-cycle sequences for wb_sram_slave.
// Four instances (wait states 1,3,0,15) share one bus; cyc is steered to the selected one.
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti = 3'd0;
    logic [1:0]  bte = 2'd0;
    int          cur;

    logic [31:0] dat_v [4];
    logic        ack_v [4];
    logic        err_v [4];
    logic        rty_v [4];

    logic [31:0] dat_m;
    logic        ack_m, err_m;

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 15;
        logic cyc_g;
        assign cyc_g = cyc && (cur == g);
        wb_sram_slave #(.DEPTH(1024), .WAIT_STATES(WS)) u_dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .wb_adr_i (adr),
            .wb_dat_i (dat),
            .wb_sel_i (sel),
            .wb_we_i  (we),
            .wb_cyc_i (cyc_g),
            .wb_stb_i (stb),
            .wb_cti_i (cti),
            .wb_bte_i (bte),
            .wb_dat_o (dat_v[g]),
            .wb_ack_o (ack_v[g]),
            .wb_err_o (err_v[g]),
            .wb_rty_o (rty_v[g])
        );
    end

    assign dat_m = dat_v[cur];
    assign ack_m = ack_v[cur];
    assign err_m = err_v[cur];

    function automatic int ws_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] bv(int i, int k);
        return 32'hB000_0000 | 32'(k << 16) | 32'(i * 273);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic ga, output logic ge, output int lat,
                        output logic [1:0] tail);
        @(negedge clk);
        we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = -1; ga = 1'b0; ge = 1'b0; rd = 32'd0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (ack_m || err_m) begin
                lat = k; ga = ack_m; ge = err_m; rd = dat_m;
            end
        end
        @(posedge clk); #1;
        tail = {ack_m, err_m};
        cyc = 1'b0; stb = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        int          lat;
    } vec_t;

    vec_t tv [14];

    task automatic btb(input int k);
        logic [31:0] rd;
        logic        ga, ge;
        logic [1:0]  tl;
        int          lt, n, ws;
        logic        got;
        cur = k;
        ws  = ws_of(k);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 32'h200 + 32'(4 * i), bv(i, k), 4'hF, rd, ga, ge, lt, tl);
            chk($sformatf("btb%0d_fill%0d", ws, i), {31'd0, ga}, 32'd1);
        end
        @(negedge clk);
        we = 1'b0; sel = 4'hF; adr = 32'h200; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0; got = 1'b0;
            while (!got && n < 60) begin
                @(posedge clk); #1;
                n++;
                if (ack_m) got = 1'b1;
            end
            chk($sformatf("btb%0d_gap%0d", ws, i), 32'(n), 32'((i == 0) ? ws + 1 : ws + 2));
            chk($sformatf("btb%0d_dat%0d", ws, i), dat_m, bv(i, k));
            adr = 32'h200 + 32'(4 * (i + 1));
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        ga, ge, seen;
        logic [1:0]  tl;
        int          lt;

        tv[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0, 1};
        tv[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1};
        tv[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0, 1};
        tv[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'h0, 1};
        tv[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 1'b0, 32'h11BB_33DD, 1};
        tv[5]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0, 1};
        tv[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 1'b0, 32'h11BB_33DD, 1};
        tv[7]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, 1};
        tv[8]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0, 0};
        tv[9]  = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0, 0};
        tv[10] = '{1'b1, 32'h0000_1000, 32'h0BAD_BAD0, 4'hF, 1'b0, 1'b1, 32'h0, 0};
        tv[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 32'hCAFE_F00D, 1};
        tv[12] = '{1'b1, 32'h0000_0FFF, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b0, 32'h0, 1};
        tv[13] = '{1'b0, 32'h0000_0FFE, 32'h0,         4'hF, 1'b1, 1'b0, 32'h5A5A_5A5A, 1};

        // reset held with a live request: nothing may answer until release
        cur = 0; rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; dat = 32'd0; sel = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_ack%0d", i), {31'd0, ack_m}, 32'd0);
            chk($sformatf("rst_err%0d", i), {31'd0, err_m}, 32'd0);
            chk($sformatf("rst_dat%0d", i), dat_m, 32'd0);
        end
        chk("rty_tied", {31'd0, rty_v[0]}, 32'd0);
        rst = 1'b0;
        lt = -1;
        for (int k = 0; k < 20 && lt < 0; k++) begin
            @(posedge clk); #1;
            if (ack_m) lt = k;
        end
        chk("rst_first_ack_lat", 32'(lt), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer(tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, rd, ga, ge, lt, tl);
            chk($sformatf("v%0d_ack", i), {31'd0, ga}, {31'd0, tv[i].ack});
            chk($sformatf("v%0d_err", i), {31'd0, ge}, {31'd0, tv[i].err});
            chk($sformatf("v%0d_lat", i), 32'(lt), 32'(tv[i].lat));
            chk($sformatf("v%0d_tail", i), {30'd0, tl}, 32'd0);
            if (!tv[i].we) chk($sformatf("v%0d_dat", i), rd, tv[i].rdat);
        end

        // abort during wait states leaves the RAM untouched
        cur = 1;
        xfer(1'b1, 32'h30, 32'h0102_0304, 4'hF, rd, ga, ge, lt, tl);
        chk("ab_pre_lat", 32'(lt), 32'd3);
        @(negedge clk);
        we = 1'b1; adr = 32'h30; dat = 32'h9999_9999; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack_m | err_m;
        end
        chk("ab_no_ack", {31'd0, seen}, 32'd0);
        xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, ga, ge, lt, tl);
        chk("ab_read_ack", {31'd0, ga}, 32'd1);
        chk("ab_read_lat", 32'(lt), 32'd3);
        chk("ab_read_dat", rd, 32'h0102_0304);

        // bus changes after capture must not leak into the request
        @(negedge clk);
        we = 1'b1; adr = 32'h34; dat = 32'h1357_9BDF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h38; dat = 32'h0; sel = 4'h0;
        lt = -1;
        for (int k = 1; k < 20 && lt < 0; k++) begin
            @(posedge clk); #1;
            if (ack_m) lt = k;
        end
        chk("mid_lat", 32'(lt), 32'd3);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        xfer(1'b0, 32'h34, 32'h0, 4'hF, rd, ga, ge, lt, tl);
        chk("mid_read_dat", rd, 32'h1357_9BDF);

        // reset while a write is pending discards it
        cur = 0;
        xfer(1'b1, 32'h50, 32'h7777_7777, 4'hF, rd, ga, ge, lt, tl);
        @(negedge clk);
        we = 1'b1; adr = 32'h50; dat = 32'h8888_8888; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        seen = ack_m | err_m;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | ack_m | err_m;
        end
        chk("rstmid_no_ack", {31'd0, seen}, 32'd0);
        xfer(1'b0, 32'h50, 32'h0, 4'hF, rd, ga, ge, lt, tl);
        chk("rstmid_read_dat", rd, 32'h7777_7777);

        btb(2);
        btb(0);
        btb(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
